frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 82 ++++++++
 tb/tb_frame_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// frame_reader: streams one frame of 8-bit pixels from word memory into a ready/valid pixel port
module frame_reader #(
  parameter int BASE_ADDR  = 152100,
  parameter int IMG_W      = 390,
  parameter int IMG_H      = 390,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_last
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] FIRST = 32'(BASE_ADDR);
  localparam logic [31:0] LAST = 32'(BASE_ADDR + IMG_W * IMG_H - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] nxt, held;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic inflight, issue, pop, room, unused_rd;
  assign unused_rd = ^mem_rd[31:8];
  assign room = ({1'b0, count} + (AW+2)'(inflight)) < (AW+2)'(FIFO_DEPTH);
  assign issue = (state == FETCH || (state == IDLE && start)) && room;
  assign pop = pix_valid && pix_ready;
  assign busy = state != IDLE;
  assign mem_we = 1'b0;
  assign mem_addr = issue ? nxt : held;
  assign pix_valid = count != '0;
  assign pix_data = pix_valid ? fifo[rptr] : 8'd0;
  assign pix_last = pix_valid && pix_x == 10'(IMG_W - 1) && pix_y == 10'(IMG_H - 1);
  always_comb begin
    state_n = state;
    state_n = state == DRAIN ? (pop && pix_last ? IDLE : DRAIN) :
              (issue && nxt == LAST) ? DRAIN :
              (state == FETCH || start) ? FETCH : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      nxt <= FIRST;
      held <= FIRST;
      inflight <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      pix_x <= '0;
      pix_y <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= issue;
      done <= pop && pix_last;
      if (state == DRAIN && state_n == IDLE) begin
        nxt <= FIRST;
        held <= FIRST;
      end else if (issue) begin
        nxt <= nxt + 32'd1;
        held <= nxt;
      end
      if (inflight) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(inflight) - (AW+1)'(pop);
      if (pop) begin
        pix_x <= pix_x == 10'(IMG_W - 1) ? 10'd0 : pix_x + 10'd1;
        pix_y <= pix_x != 10'(IMG_W - 1) ? pix_y : pix_y == 10'(IMG_H - 1) ? 10'd0 : pix_y + 10'd1;
      end
    end
  always_ff @(posedge clk)
    if (inflight) fifo[wptr] <= mem_rd[7:0];
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: directed checks of frame_reader on a 4x2 frame plus a default-size instance
module tb_frame_reader;
  logic clk, rst, start, pix_ready, busy, done, mem_we, pix_valid, pix_last;
  logic [31:0] mem_addr, mem_rd;
  logic [7:0] pix_data;
  logic [9:0] pix_x, pix_y;
  logic d_start, d_ready, d_busy, d_done, d_we, d_valid, d_last;
  logic [31:0] d_addr, d_rd;
  logic [7:0] d_data;
  logic [9:0] d_x, d_y;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int n_xfer = 0, n_done = 0, done_c = 0, last_a = 0;
  logic done_b = 1'b0;
  int rec_d [128], rec_x [128], rec_y [128], rec_c [128];
  logic rec_l [128];
  int d_n = 0, d389 [3], d390 [4];
  logic d_we_seen = 1'b0;
  int b, bd, s;

  frame_reader #(.BASE_ADDR(152100), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_rd(mem_rd),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last));

  frame_reader dflt (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .mem_addr(d_addr), .mem_we(d_we), .mem_rd(d_rd),
    .pix_valid(d_valid), .pix_ready(d_ready), .pix_data(d_data),
    .pix_x(d_x), .pix_y(d_y), .pix_last(d_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd <= mem_addr - 32'd152100 + 32'd16;
  always @(posedge clk) d_rd <= d_addr - 32'd152100 + 32'd16;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      if (n_xfer < 128) begin
        rec_d[n_xfer] <= int'(pix_data);
        rec_x[n_xfer] <= int'(pix_x);
        rec_y[n_xfer] <= int'(pix_y);
        rec_l[n_xfer] <= pix_last;
        rec_c[n_xfer] <= cyc;
      end
      n_xfer <= n_xfer + 1;
      if (pix_last) last_a <= int'(mem_addr);
    end
    if (done) begin
      n_done <= n_done + 1;
      done_c <= cyc;
      done_b <= busy;
    end
    if (d_we) d_we_seen <= 1'b1;
    if (d_valid && d_ready) begin
      if (d_n == 389) d389 <= '{int'(d_x), int'(d_y), int'(d_data)};
      if (d_n == 390) d390 <= '{int'(d_x), int'(d_y), int'(d_data), cyc};
      d_n <= d_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, mem_addr, 152100);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_last"}, pix_last, 0);
  endtask

  task automatic check_frame(input string tag, input int fb, input int fd);
    chk({tag, "_count"}, n_xfer - fb, 8);
    chk({tag, "_ndone"}, n_done - fd, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", tag, i), rec_d[fb+i], 16 + i);
      chk($sformatf("%s_xy%0d", tag, i), rec_y[fb+i] * 1024 + rec_x[fb+i], (i / 4) * 1024 + i % 4);
      chk($sformatf("%s_last%0d", tag, i), rec_l[fb+i], i == 7);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_ready = 1'b1; d_start = 1'b0; d_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_reset("rst");
    tick(1);
    rst = 1'b1;
    tick(2);
    // nominal frame with pix_ready held high
    b = n_xfer; bd = n_done; start = 1'b1; s = cyc;
    @(negedge clk);
    chk("t1_addr0", mem_addr, 152100);
    chk("t1_busy0", busy, 0);
    tick(1); start = 1'b0;
    @(negedge clk);
    chk("t1_busy1", busy, 1);
    chk("t1_valid1", pix_valid, 0);
    chk("t1_addr1", mem_addr, 152101);
    tick(1);
    @(negedge clk);
    chk("t1_valid2", pix_valid, 1);
    chk("t1_data2", pix_data, 16);
    tick(20);
    check_frame("t1", b, bd);
    chk("t1_lat", rec_c[b] - s, 2);
    chk("t1_burst", rec_c[b+7] - rec_c[b], 7);
    chk("t1_lastaddr", last_a, 152107);
    chk("t1_donecyc", done_c - rec_c[b+7], 1);
    chk("t1_donebusy", done_b, 0);
    // downstream stalled for 10 cycles after start
    pix_ready = 1'b0; tick(1);
    b = n_xfer; bd = n_done; start = 1'b1;
    tick(1); start = 1'b0;
    tick(4);
    @(negedge clk);
    chk("t2_addr5", mem_addr, 152103);
    chk("t2_valid5", pix_valid, 1);
    chk("t2_data5", pix_data, 16);
    tick(4);
    @(negedge clk);
    chk("t2_addr9", mem_addr, 152103);
    chk("t2_data9", pix_data, 16);
    chk("t2_x9", pix_x, 0);
    chk("t2_none9", n_xfer - b, 0);
    tick(1); pix_ready = 1'b1;
    tick(30);
    check_frame("t2", b, bd);
    // pix_ready toggling every cycle
    b = n_xfer; bd = n_done; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      start = 1'b0;
      pix_ready = ~pix_ready;
    end
    pix_ready = 1'b1;
    tick(5);
    check_frame("t3", b, bd);
    // start while busy is ignored; start during done launches the next frame
    b = n_xfer; bd = n_done; start = 1'b1;
    tick(1); start = 1'b0;
    tick(2); start = 1'b1;
    tick(1); start = 1'b0;
    for (int i = 0; i < 30 && !done; i++) tick(1);
    chk("t4_doneseen", done, 1);
    start = 1'b1;
    tick(1); start = 1'b0;
    check_frame("t4", b, bd);
    @(negedge clk);
    chk("t4_busy_again", busy, 1);
    b = n_xfer; bd = n_done;
    tick(20);
    check_frame("t4b", b, bd);
    // reset in the middle of a frame
    b = n_xfer; start = 1'b1;
    tick(1); start = 1'b0;
    tick(4); rst = 1'b0;
    @(negedge clk);
    check_reset("t5rst");
    chk("t5_three", n_xfer - b, 3);
    tick(2); rst = 1'b1;
    tick(5);
    @(negedge clk);
    chk("t5_quiet", n_xfer - b, 3);
    chk("t5_novalid", pix_valid, 0);
    tick(1);
    b = n_xfer; bd = n_done; start = 1'b1;
    @(negedge clk);
    chk("t5_addr0", mem_addr, 152100);
    tick(1); start = 1'b0;
    tick(20);
    check_frame("t5", b, bd);
    // default geometry: row wrap at 389 and sustained throughput
    d_start = 1'b1; s = cyc;
    tick(1); d_start = 1'b0;
    tick(400);
    chk("t6_x389", d389[0], 389);
    chk("t6_y389", d389[1], 0);
    chk("t6_d389", d389[2], 149);
    chk("t6_x390", d390[0], 0);
    chk("t6_y390", d390[1], 1);
    chk("t6_d390", d390[2], 150);
    chk("t6_cyc390", d390[3] - s, 392);
    chk("t6_count", d_n, 399);
    chk("t6_we", d_we_seen, 0);
    chk("t6_busy", d_busy, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
